// File: rtl/gfx_pkg.sv
// Shared definitions for the blit engine: state encoding, register map and bus widths.
// The GFX_BLIT_FILL_EN macro enables the constant-fill mode in the register block.
package gfx_pkg;

  localparam int unsigned SrcAw = 15;
  localparam int unsigned DstAw = 16;
  localparam int unsigned LenW  = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StRd   = 2'd2,
    StWr   = 2'd3
  } blit_state_e;

  localparam logic [2:0] RegSrcLo = 3'd0;
  localparam logic [2:0] RegSrcHi = 3'd1;
  localparam logic [2:0] RegDstLo = 3'd2;
  localparam logic [2:0] RegDstHi = 3'd3;
  localparam logic [2:0] RegLenLo = 3'd4;
  localparam logic [2:0] RegLenHi = 3'd5;
  localparam logic [2:0] RegCtrl  = 3'd6;
  localparam logic [2:0] RegFill  = 3'd7;

  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlAbort = 1;
  localparam int unsigned CtrlFill  = 2;

endpackage

// File: rtl/gfx_blit_regs.sv
// CPU register window of the blit engine: decode, CTRL strobes and write lock while busy.
// FILL bit and register 7 exist only when GFX_BLIT_FILL_EN is defined.
module gfx_blit_regs
  import gfx_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ctrl_ce_b_i,
  input  logic             ctrl_we_b_i,
  input  logic [2:0]       ctrl_addr_i,
  input  logic [7:0]       ctrl_data_i,
  input  logic             busy_i,
  output logic [SrcAw-1:0] src_o,
  output logic [DstAw-1:0] dst_o,
  output logic [LenW-1:0]  len_o,
  output logic [7:0]       fill_val_o,
  output logic             start_o,
  output logic             abort_o,
  output logic             fill_o
);

  logic [7:0] src_lo_q, dst_lo_q, dst_hi_q, len_lo_q, len_hi_q;
  logic [6:0] src_hi_q;
  logic       wr_en, wr_ctrl;

  assign wr_en   = !ctrl_ce_b_i && !ctrl_we_b_i;
  assign wr_ctrl = wr_en && (ctrl_addr_i == RegCtrl);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_lo_q <= '0;
      src_hi_q <= '0;
      dst_lo_q <= '0;
      dst_hi_q <= '0;
      len_lo_q <= '0;
      len_hi_q <= '0;
    end else if (wr_en && !busy_i) begin
      case (ctrl_addr_i)
        RegSrcLo: src_lo_q <= ctrl_data_i;
        RegSrcHi: src_hi_q <= ctrl_data_i[6:0];
        RegDstLo: dst_lo_q <= ctrl_data_i;
        RegDstHi: dst_hi_q <= ctrl_data_i;
        RegLenLo: len_lo_q <= ctrl_data_i;
        RegLenHi: len_hi_q <= ctrl_data_i;
        default: ;
      endcase
    end
  end

`ifdef GFX_BLIT_FILL_EN
  logic [7:0] fill_val_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_val_q <= '0;
    end else if (wr_en && !busy_i && (ctrl_addr_i == RegFill)) begin
      fill_val_q <= ctrl_data_i;
    end
  end

  assign fill_val_o = fill_val_q;
  assign fill_o     = wr_ctrl && ctrl_data_i[CtrlFill];
`else
  assign fill_val_o = '0;
  assign fill_o     = 1'b0;
`endif

  assign src_o = {src_hi_q, src_lo_q};
  assign dst_o = {dst_hi_q, dst_lo_q};
  assign len_o = {len_hi_q, len_lo_q};

  // Strobes act in the same edge as the CTRL write; START only from idle, ABORT only while busy.
  assign start_o = wr_ctrl && ctrl_data_i[CtrlStart] && !busy_i;
  assign abort_o = wr_ctrl && ctrl_data_i[CtrlAbort] && busy_i;

endmodule

// File: rtl/gfx_blit_engine.sv
// Data-RAM to VRAM copy engine that borrows both buses during VGA-free windows.
// With GFX_BLIT_FILL_EN defined, a FILL transfer writes a constant without reading data RAM.
module gfx_blit_engine
  import gfx_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ctrl_ce_b,
  input  logic             i_ctrl_we_b,
  input  logic [2:0]       i_ctrl_addr,
  input  logic [7:0]       i_ctrl_data,
  input  logic             i_free_vbus_b,
  output logic             o_active,
  output logic             o_addr_sel,
  output logic             o_src_re_b,
  output logic [SrcAw-1:0] o_src_addr,
  input  logic [7:0]       i_src_data,
  output logic             o_dst_we_b,
  output logic [DstAw-1:0] o_dst_addr,
  output logic [7:0]       o_dst_data,
  output logic             o_busy,
  output logic             o_done
);

  blit_state_e      state_q, state_d;
  logic [SrcAw-1:0] src_q, src_d, reg_src;
  logic [DstAw-1:0] dst_q, dst_d, reg_dst;
  logic [LenW-1:0]  len_q, len_d, reg_len;
  logic [7:0]       byte_q, byte_d, reg_fill_val;
  logic             fill_mode_q, fill_mode_d;
  logic             done_d, start, abort, fill;
  logic             busy_now;

  assign busy_now = (state_q != StIdle);

  gfx_blit_regs u_regs (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .ctrl_ce_b_i (i_ctrl_ce_b),
    .ctrl_we_b_i (i_ctrl_we_b),
    .ctrl_addr_i (i_ctrl_addr),
    .ctrl_data_i (i_ctrl_data),
    .busy_i      (busy_now),
    .src_o       (reg_src),
    .dst_o       (reg_dst),
    .len_o       (reg_len),
    .fill_val_o  (reg_fill_val),
    .start_o     (start),
    .abort_o     (abort),
    .fill_o      (fill)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    byte_d      = byte_q;
    fill_mode_d = fill_mode_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (reg_len != '0) begin
            state_d     = StWait;
            src_d       = reg_src;
            dst_d       = reg_dst;
            len_d       = reg_len;
            fill_mode_d = fill;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (!i_free_vbus_b) state_d = fill_mode_q ? StWr : StRd;
      end
      StRd: begin
        byte_d  = i_src_data;
        state_d = StWr;
      end
      StWr: begin
        dst_d = dst_q + 1'b1;
        len_d = len_q - 1'b1;
        if (!fill_mode_q) src_d = src_q + 1'b1;
        if (len_q == LenW'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (!i_free_vbus_b) begin
          state_d = fill_mode_q ? StWr : StRd;
        end else begin
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  // Outputs are registered from next-state so strobes and their address/data share one edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      byte_q      <= '0;
      fill_mode_q <= 1'b0;
      o_active    <= 1'b0;
      o_addr_sel  <= 1'b0;
      o_src_re_b  <= 1'b1;
      o_src_addr  <= '0;
      o_dst_we_b  <= 1'b1;
      o_dst_addr  <= '0;
      o_dst_data  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      byte_q      <= byte_d;
      fill_mode_q <= fill_mode_d;
      o_active    <= (state_d == StRd);
      o_addr_sel  <= (state_d == StRd) || (state_d == StWr);
      o_src_re_b  <= (state_d != StRd);
      o_src_addr  <= (state_d == StRd) ? src_d : '0;
      o_dst_we_b  <= (state_d != StWr);
      o_dst_addr  <= (state_d == StWr) ? dst_d : '0;
      o_dst_data  <= (state_d == StWr) ? (fill_mode_d ? reg_fill_val : byte_d) : 8'h00;
      o_busy      <= (state_d != StIdle);
      o_done      <= done_d;
    end
  end

endmodule

// File: tb/tb_gfx_blit_engine.sv
// Scoreboard bench for gfx_blit_engine: expected reads/writes are queued per transfer from
// address arithmetic over a random data-RAM image; a negedge monitor checks bus activity.
module tb_gfx_blit_engine;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_ctrl_ce_b = 1'b1;
  logic        i_ctrl_we_b = 1'b1;
  logic [2:0]  i_ctrl_addr = '0;
  logic [7:0]  i_ctrl_data = '0;
  logic        i_free_vbus_b = 1'b0;
  logic        o_active, o_addr_sel, o_src_re_b, o_dst_we_b, o_busy, o_done;
  logic [14:0] o_src_addr;
  logic [15:0] o_dst_addr;
  logic [7:0]  o_dst_data;
  logic [7:0]  i_src_data;

  logic [7:0]  mem [0:32767];
  assign i_src_data = mem[o_src_addr];

  gfx_blit_engine dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ctrl_ce_b   (i_ctrl_ce_b),
    .i_ctrl_we_b   (i_ctrl_we_b),
    .i_ctrl_addr   (i_ctrl_addr),
    .i_ctrl_data   (i_ctrl_data),
    .i_free_vbus_b (i_free_vbus_b),
    .o_active      (o_active),
    .o_addr_sel    (o_addr_sel),
    .o_src_re_b    (o_src_re_b),
    .o_src_addr    (o_src_addr),
    .i_src_data    (i_src_data),
    .o_dst_we_b    (o_dst_we_b),
    .o_dst_addr    (o_dst_addr),
    .o_dst_data    (o_dst_data),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cyc = 0;
  int start_cyc = 0;
  int done_count = 0;
  int done_expected = 0;
  int last_done_cyc = 0;
  int wr_count = 0;
  int rd_count = 0;
  bit prev_done = 1'b0;
  logic free_at_edge = 1'b0;
  logic [23:0] wq [$];
  logic [14:0] rq [$];

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    free_at_edge <= i_free_vbus_b;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every observed bus strobe must match the head of the expected queue.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (!o_src_re_b) begin
        check("rd_bus_was_free", 64'(free_at_edge), 64'd0);
        check("rd_owns_buses", {62'd0, o_active, o_addr_sel}, 64'd3);
        check("rd_wr_exclusive", 64'(o_dst_we_b), 64'd1);
        if (rq.size() == 0) fail_now($sformatf("unexpected_read addr=0x%0h", o_src_addr));
        else check("rd_addr", 64'(o_src_addr), 64'(rq.pop_front()));
        rd_count++;
      end else begin
        check("active_only_in_rd", 64'(o_active), 64'd0);
      end
      if (!o_dst_we_b) begin
        check("wr_owns_vram", 64'(o_addr_sel), 64'd1);
        if (wq.size() == 0) fail_now($sformatf("unexpected_write addr=0x%0h", o_dst_addr));
        else check("wr_addr_data", {40'd0, o_dst_addr, o_dst_data}, 64'(wq.pop_front()));
        wr_count++;
      end else if (o_src_re_b) begin
        check("idle_no_addr_sel", 64'(o_addr_sel), 64'd0);
      end
      if (o_done) begin
        done_count++;
        last_done_cyc = cyc;
        check("busy_low_at_done", 64'(o_busy), 64'd0);
        check("writes_drained_at_done", 64'(wq.size()), 64'd0);
        check("done_single_cycle", 64'(prev_done), 64'd0);
      end
      prev_done = o_done;
    end
  end

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    i_ctrl_ce_b = 1'b0;
    i_ctrl_we_b = 1'b0;
    i_ctrl_addr = a;
    i_ctrl_data = d;
    @(posedge i_clk);
    #1 wr_cyc = cyc;
    @(negedge i_clk);
    i_ctrl_ce_b = 1'b1;
    i_ctrl_we_b = 1'b1;
  endtask

  task automatic program_regs(input int src, input int dst, input int len);
    wr_reg(3'd0, 8'(src));
    wr_reg(3'd1, 8'(src >> 8));
    wr_reg(3'd2, 8'(dst));
    wr_reg(3'd3, 8'(dst >> 8));
    wr_reg(3'd4, 8'(len));
    wr_reg(3'd5, 8'(len >> 8));
  endtask

  // Reference model: byte k goes from src+k (mod 32K) to dst+k (mod 64K).
  task automatic start_xfer(input int src, input int dst, input int len, input bit fill,
                            input logic [7:0] fv);
    program_regs(src, dst, len);
    if (fill) wr_reg(3'd7, fv);
    for (int k = 0; k < len; k++) begin
      if (!fill) rq.push_back(15'((src + k) % 32768));
      wq.push_back({16'((dst + k) % 65536), fill ? fv : mem[(src + k) % 32768]});
    end
    done_expected++;
    wr_reg(3'd6, fill ? 8'h05 : 8'h01);
    start_cyc = wr_cyc;
  endtask

  task automatic wait_done(input int limit, input bit rnd);
    int n = 0;
    while (done_count != done_expected && n < limit) begin
      @(negedge i_clk);
      #1;
      if (rnd) i_free_vbus_b = ($urandom_range(0, 3) == 0);
      n++;
    end
    i_free_vbus_b = 1'b0;
    if (done_count != done_expected) fail_now("wait_done_timeout");
  endtask

  task automatic wait_count(input string name, input int target, input bit use_rd);
    int n = 0;
    while ((use_rd ? rd_count : wr_count) < target && n < 200) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    if ((use_rd ? rd_count : wr_count) < target) fail_now(name);
  endtask

  task automatic check_bus_idle(input string name);
    check(name, {58'd0, o_active, o_addr_sel, o_src_re_b, o_dst_we_b, o_busy, o_done},
          64'b001100);
  endtask

  int base_wr, base_rd;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);

    // Reset values
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    check_bus_idle("reset_ctrl_outputs");
    check("reset_addr_data", {25'd0, o_src_addr, o_dst_addr, o_dst_data}, 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Basic copy with the bus free
    base_wr = wr_count; base_rd = rd_count;
    start_xfer(32'h0100, 32'h8000, 4, 1'b0, 8'h00);
    check("t1_busy_after_start", 64'(o_busy), 64'd1);
    wait_done(100, 1'b0);
    check("t1_done_latency", 64'(last_done_cyc - start_cyc), 64'd9);
    check("t1_write_count", 64'(wr_count - base_wr), 64'd4);
    check("t1_read_count", 64'(rd_count - base_rd), 64'd4);

    // Bus taken back during the second read
    base_wr = wr_count;
    base_rd = rd_count;
    start_xfer(32'h1000, 32'h0040, 3, 1'b0, 8'h00);
    wait_count("t2_second_read_timeout", base_rd + 2, 1'b1);
    i_free_vbus_b = 1'b1;
    @(negedge i_clk);
    #1 check("t2_wr_after_rd_completes", 64'(wr_count - base_wr), 64'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      #1 check("t2_wait_bus_inactive",
               {60'd0, o_active, o_addr_sel, o_src_re_b, o_dst_we_b}, 64'b0011);
      check("t2_wait_busy", 64'(o_busy), 64'd1);
    end
    i_free_vbus_b = 1'b0;
    wait_done(100, 1'b0);
    check("t2_write_count", 64'(wr_count - base_wr), 64'd3);

    // Address wrap on both sides
    start_xfer(32'h7FFF, 32'hFFFE, 3, 1'b0, 8'h00);
    wait_done(100, 1'b0);
    check("t3_done_latency", 64'(last_done_cyc - start_cyc), 64'd7);

    // LEN=0 start, then locked writes and a second START while busy
    base_wr = wr_count;
    program_regs(32'h0000, 32'h0000, 0);
    done_expected++;
    wr_reg(3'd6, 8'h01);
    #1 check("t4_len0_done", 64'(done_count), 64'(done_expected));
    check("t4_len0_latency", 64'(last_done_cyc - wr_cyc), 64'd0);
    i_free_vbus_b = 1'b1;
    start_xfer(32'h0200, 32'h1234, 6, 1'b0, 8'h00);
    wr_reg(3'd0, 8'h55);
    wr_reg(3'd3, 8'h77);
    wr_reg(3'd4, 8'h01);
    wr_reg(3'd6, 8'h01);
    check("t4_held_in_wait", 64'(wr_count - base_wr), 64'd0);
    i_free_vbus_b = 1'b0;
    wait_done(100, 1'b0);
    repeat (5) @(negedge i_clk);
    #1 check("t4_no_extra_done", 64'(done_count), 64'(done_expected));
    check("t4_write_count", 64'(wr_count - base_wr), 64'd6);

    // ABORT after two bytes
    base_wr = wr_count;
    start_xfer(32'h0300, 32'h4000, 10, 1'b0, 8'h00);
    wait_count("t5_second_write_timeout", base_wr + 2, 1'b0);
    i_free_vbus_b = 1'b1;
    @(negedge i_clk);
    #1 wr_reg(3'd6, 8'h02);
    #1 check_bus_idle("t5_abort_outputs");
    check("t5_pending_writes", 64'(wq.size()), 64'd8);
    check("t5_pending_reads", 64'(rq.size()), 64'd8);
    wq.delete();
    rq.delete();
    done_expected--;
    i_free_vbus_b = 1'b0;
    repeat (4) @(negedge i_clk);
    #1 check("t5_no_done_after_abort", 64'(done_count), 64'(done_expected));
    check("t5_no_writes_after_abort", 64'(wr_count - base_wr), 64'd2);

    // Reset in the middle of a transfer
    start_xfer(32'h0400, 32'h2000, 8, 1'b0, 8'h00);
    repeat (5) @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 check_bus_idle("t6_reset_ctrl_outputs");
    check("t6_reset_addr_data", {25'd0, o_src_addr, o_dst_addr, o_dst_data}, 64'd0);
    wq.delete();
    rq.delete();
    done_expected--;
    @(negedge i_clk);
    i_rst = 1'b0;
    base_wr = wr_count;
    repeat (3) @(negedge i_clk);
    #1 check("t6_no_done_after_reset", 64'(done_count), 64'(done_expected));
    // Registers were cleared, so START now sees LEN=0
    done_expected++;
    wr_reg(3'd6, 8'h01);
    #1 check("t6_regs_cleared_len0", 64'(done_count), 64'(done_expected));
    repeat (3) @(negedge i_clk);
    check("t6_no_bus_activity", 64'(wr_count - base_wr), 64'd0);

    // Randomized transfers with a randomly released VRAM bus
    for (int t = 0; t < 15; t++) begin
      base_wr = wr_count;
      start_xfer(int'($urandom_range(0, 32767)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(1, 24)), 1'b0, 8'h00);
      wait_done(3000, 1'b1);
      @(negedge i_clk);
    end

`ifdef GFX_BLIT_FILL_EN
    base_wr = wr_count;
    base_rd = rd_count;
    start_xfer(32'h0123, 32'h9000, 5, 1'b1, 8'hA5);
    wait_done(100, 1'b0);
    check("t7_fill_latency", 64'(last_done_cyc - start_cyc), 64'd6);
    check("t7_fill_writes", 64'(wr_count - base_wr), 64'd5);
    check("t7_fill_no_reads", 64'(rd_count - base_rd), 64'd0);
`endif

    repeat (3) @(negedge i_clk);
    check("total_done_pulses", 64'(done_count), 64'(done_expected));
    check("queues_empty", 64'(wq.size() + rq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
